// File: rtl/node_output_queue_if.sv
// Routed-instruction ingress and the three drained FIFO egress ports of a ring node.
// slave: the queue itself; master: whoever feeds the queue and consumes its outputs.
interface node_output_queue_if #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
);
    logic             valid_in;
    logic [1:0]       route_in;
    logic [31:0]      instruction_in;

    logic [31:0]      cw_data,  ccw_data,  local_data;
    logic             cw_valid, ccw_valid, local_valid;
    logic             cw_ready, ccw_ready, local_ready;
    logic [PTR_W:0]   cw_count, ccw_count, local_count;
    logic [7:0]       drop_count;

    modport slave (
        input  valid_in, route_in, instruction_in,
        input  cw_ready, ccw_ready, local_ready,
        output cw_data, ccw_data, local_data,
        output cw_valid, ccw_valid, local_valid,
        output cw_count, ccw_count, local_count,
        output drop_count
    );

    modport master (
        output valid_in, route_in, instruction_in,
        output cw_ready, ccw_ready, local_ready,
        input  cw_data, ccw_data, local_data,
        input  cw_valid, ccw_valid, local_valid,
        input  cw_count, ccw_count, local_count,
        input  drop_count
    );
endinterface

// File: rtl/node_output_queue.sv
// Steers routed instructions into cw / ccw / local FIFOs; drops (and counts) overflow
// and invalid routes because the upstream controller cannot be stalled.
module noq_fifo #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_req,
    input  logic [31:0]      push_data,
    input  logic             ready,
    output logic [31:0]      data,
    output logic             valid,
    output logic [PTR_W:0]   count,
    output logic             push_ok
);
    logic [31:0]      mem [DEPTH];
    logic [PTR_W-1:0] wptr, rptr;
    logic             pop, full;

    assign valid   = (count != '0);
    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign pop     = valid && ready;
    // A full FIFO still accepts when its head leaves on the same edge.
    assign push_ok = push_req && (!full || pop);
    assign data    = valid ? mem[rptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is not reset; outputs are masked by valid.
    always_ff @(posedge clk) begin
        if (push_ok && !reset) mem[wptr] <= push_data;
    end
endmodule

module node_output_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    node_output_queue_if.slave   bus
);
    localparam int N = 3;
    // Lane order: 0 = cw, 1 = ccw, 2 = local.
    localparam logic [N-1:0][1:0] ROUTE_CODE = {2'b01, 2'b10, 2'b00};

    logic [N-1:0]            push_req, push_ok, valid, ready;
    logic [N-1:0][31:0]      data;
    logic [N-1:0][PTR_W:0]   count;
    logic [7:0]              drop_q;
    logic                    drop;

    assign ready = {bus.local_ready, bus.ccw_ready, bus.cw_ready};

    generate
        for (genvar g = 0; g < N; g++) begin : g_lane
            assign push_req[g] = bus.valid_in && (bus.route_in == ROUTE_CODE[g]);
            noq_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
                .clk       (clk),
                .reset     (reset),
                .push_req  (push_req[g]),
                .push_data (bus.instruction_in),
                .ready     (ready[g]),
                .data      (data[g]),
                .valid     (valid[g]),
                .count     (count[g]),
                .push_ok   (push_ok[g])
            );
        end
    endgenerate

    // Route 11 matches no lane, so it falls out as a drop here too.
    assign drop = bus.valid_in && (push_ok == '0);

    always_ff @(posedge clk) begin
        if (reset)                        drop_q <= '0;
        else if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
    end

    assign bus.cw_data     = data[0];
    assign bus.ccw_data    = data[1];
    assign bus.local_data  = data[2];
    assign bus.cw_valid    = valid[0];
    assign bus.ccw_valid   = valid[1];
    assign bus.local_valid = valid[2];
    assign bus.cw_count    = count[0];
    assign bus.ccw_count   = count[1];
    assign bus.local_count = count[2];
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_node_output_queue.sv
// Randomized and directed stimulus for node_output_queue, checked against a queue-based model.
module tb_node_output_queue;
    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    node_output_queue_if #(.DEPTH(DEPTH), .PTR_W(PTR_W)) bus ();

    node_output_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] q [3][$];
    int          drops = 0;

    logic [31:0]    od [3];
    logic           ov [3];
    logic [PTR_W:0] oc [3];
    assign od[0] = bus.cw_data;    assign od[1] = bus.ccw_data;    assign od[2] = bus.local_data;
    assign ov[0] = bus.cw_valid;   assign ov[1] = bus.ccw_valid;   assign ov[2] = bus.local_valid;
    assign oc[0] = bus.cw_count;   assign oc[1] = bus.ccw_count;   assign oc[2] = bus.local_count;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int tgt(input logic [1:0] r);
        case (r)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b01:   return 2;
            default: return -1;
        endcase
    endfunction

    task automatic check_all();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("valid%0d", i), 32'(ov[i]), 32'(q[i].size() > 0));
            chk($sformatf("data%0d", i), od[i], (q[i].size() > 0) ? q[i][0] : 32'h0);
            chk($sformatf("count%0d", i), 32'(oc[i]), 32'(q[i].size()));
        end
        chk("drop_count", 32'(bus.drop_count), 32'(drops));
    endtask

    // One clock: drive inputs, advance the model on the edge, compare 1 time unit later.
    task automatic step(input logic v, input logic [1:0] r, input logic [31:0] d, input logic [2:0] rdy);
        bit pop [3];
        int t;
        bus.valid_in = v; bus.route_in = r; bus.instruction_in = d;
        bus.cw_ready = rdy[0]; bus.ccw_ready = rdy[1]; bus.local_ready = rdy[2];
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 3; i++) q[i].delete();
            drops = 0;
        end else begin
            for (int i = 0; i < 3; i++) pop[i] = rdy[i] && (q[i].size() > 0);
            t = tgt(r);
            for (int i = 0; i < 3; i++) if (pop[i]) void'(q[i].pop_front());
            if (v) begin
                if (t >= 0 && (q[t].size() < DEPTH || pop[t])) q[t].push_back(d);
                else if (drops < 255) drops++;
            end
        end
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] first_cw;
        bus.valid_in = 0; bus.route_in = 0; bus.instruction_in = 0;
        bus.cw_ready = 0; bus.ccw_ready = 0; bus.local_ready = 0;

        // Reset, then one push per route
        reset = 1;
        step(1, 2'b00, 32'hDEAD_0000, 3'b000);
        step(0, 2'b00, 32'h0, 3'b000);
        chk("rst_drop", 32'(bus.drop_count), 32'h0);
        reset = 0;
        step(1, 2'b00, 32'h1234_5678, 3'b000);
        chk("cw_first", bus.cw_data, 32'h1234_5678);
        step(1, 2'b10, 32'hAAAA_0001, 3'b000);
        chk("ccw_first", bus.ccw_data, 32'hAAAA_0001);
        step(1, 2'b01, 32'h5555_0002, 3'b000);
        chk("local_first", bus.local_data, 32'h5555_0002);
        chk("local_cnt1", 32'(bus.local_count), 32'd1);
        for (int i = 0; i < 3; i++) step(0, 2'b00, 32'h0, 3'b111);

        // Fill and overflow cw
        for (int i = 0; i < 5; i++) step(1, 2'b00, 32'h100 + 32'(i), 3'b000);
        chk("cw_full_cnt", 32'(bus.cw_count), 32'd4);
        chk("overflow_drop", 32'(bus.drop_count), 32'd1);
        first_cw = bus.cw_data;
        chk("cw_head_order", first_cw, 32'h100);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 32'h0, 3'b001);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) step(1, 2'b00, 32'h200 + 32'(i), 3'b000);
        step(1, 2'b00, 32'h2FF, 3'b001);
        chk("full_pop_cnt", 32'(bus.cw_count), 32'd4);
        chk("full_pop_drop", 32'(bus.drop_count), 32'd1);
        for (int i = 0; i < 4; i++) step(0, 2'b00, 32'h0, 3'b001);

        // Invalid route and saturation
        for (int i = 0; i < 300; i++) step(1, 2'b11, $urandom, 3'($urandom));
        chk("drop_sat", 32'(bus.drop_count), 32'd255);

        // Wrap-around streaming on local
        for (int i = 0; i < 20; i++) begin
            step(1, 2'b01, 32'h300 + 32'(i), 3'b100);
            chk("local_le1", 32'(bus.local_count <= 1), 32'd1);
        end
        step(0, 2'b00, 32'h0, 3'b100);

        // Random traffic, alternating drain-heavy and backpressure-heavy phases
        for (int i = 0; i < 800; i++) begin
            logic [2:0] rdy;
            if ((i / 200) % 2 == 0) rdy = 3'($urandom);
            else rdy = {3{1'b0}} | {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            step($urandom_range(0, 3) != 0, 2'($urandom), $urandom, rdy);
        end

        // Reset mid-operation with a push and a pop on the same edge
        reset = 1; step(0, 2'b00, 32'h0, 3'b000); reset = 0;
        for (int i = 0; i < 3; i++) step(1, 2'b00, 32'h400 + 32'(i), 3'b000);
        step(1, 2'b11, 32'h0, 3'b000);
        reset = 1;
        step(1, 2'b00, 32'h4FF, 3'b001);
        reset = 0;
        chk("mid_rst_cw_valid", 32'(bus.cw_valid), 32'd0);
        chk("mid_rst_cw_cnt", 32'(bus.cw_count), 32'd0);
        chk("mid_rst_drop", 32'(bus.drop_count), 32'd0);
        step(1, 2'b01, 32'hCAFE_F00D, 3'b000);
        chk("post_rst_local", bus.local_data, 32'hCAFE_F00D);
        chk("post_rst_valid", 32'(bus.local_valid), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
